// File: rtl/debounce_pkg.sv
// Shared constants and elaboration-time helpers for the debounce scheduler and
// other slot-scheduled blocks.
package debounce_pkg;

   localparam int unsigned DEBOUNCE_TICK_DIV     = 50000;
   localparam int unsigned DEBOUNCE_STABLE_COUNT = 4;

   // Ceiling log2; clog2(1) == 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      longint unsigned span;
      result = 0;
      span   = 1;
      while (span < value) begin
         span   = span << 1;
         result = result + 1;
      end
      return result;
   endfunction

   // Width of a field that must hold values 0..n-1, never narrower than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/slot_timer.sv
// Sample-slot timer: asserts tick for one cycle out of every TICK_DIV cycles.
// Implemented as a down-counter so the terminal count is a compare against
// zero. remain == TICK_DIV-1-div, so tick lines up with div == TICK_DIV-1.
// After reset the first tick comes TICK_DIV-1 edges later.
module slot_timer
   import debounce_pkg::*;
#(
   parameter int unsigned TICK_DIV = DEBOUNCE_TICK_DIV
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned DIV_W = width_of(TICK_DIV);
   localparam logic [DIV_W-1:0] RELOAD = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] remain;

   // Count down to zero, then reload; reset loads the full period.
   always_ff @(posedge clk) begin
      if (reset) begin
         remain <= RELOAD;
      end else if (remain == '0) begin
         remain <= RELOAD;
      end else begin
         remain <= remain - 1'b1;
      end
   end

   assign tick = (remain == '0);

endmodule

// File: rtl/debounce_scheduler.sv
// Round-robin switch debouncer. One shared slot timer picks one channel per
// slot. A single compare/update path then advances or clears that channel's
// count, or flips its level.
module debounce_scheduler
   import debounce_pkg::*;
#(
   parameter int unsigned N_CH         = 4,
   parameter int unsigned TICK_DIV     = DEBOUNCE_TICK_DIV,
   parameter int unsigned STABLE_COUNT = DEBOUNCE_STABLE_COUNT
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_CH-1:0]             sw_in,
   output logic [N_CH-1:0]             sw_level,
   output logic [N_CH-1:0]             sw_rise,
   output logic [N_CH-1:0]             sw_fall,
   output logic [width_of(N_CH)-1:0]   slot_ch,
   output logic                        slot_tick
);

   localparam int unsigned CH_W  = width_of(N_CH);
   localparam int unsigned CNT_W = width_of(STABLE_COUNT + 1);
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

   logic [N_CH-1:0]  sync_meta;
   logic [N_CH-1:0]  sync_q;
   logic [CNT_W-1:0] cnt [N_CH];

   logic             cur_sync;
   logic             cur_level;
   logic [CNT_W-1:0] cur_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             cur_flip;

   // Two-flop synchronizer on every raw input, running every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= sw_in;
         sync_q    <= sync_meta;
      end
   end

   slot_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_slot_timer (
      .clk   (clk),
      .reset (reset),
      .tick  (slot_tick)
   );

   // Shared datapath: evaluate the channel currently pointed to by slot_ch.
   always_comb begin
      cur_sync  = sync_q[slot_ch];
      cur_level = sw_level[slot_ch];
      cur_cnt   = cnt[slot_ch];
      cur_flip  = 1'b0;
      cnt_next  = '0;
      if (cur_sync != cur_level) begin
         if (cur_cnt == CNT_LAST) begin
            cur_flip = 1'b1;
         end else begin
            cnt_next = cur_cnt + 1'b1;
         end
      end
   end

   // Per-channel state. Only the scheduled channel is written on a slot tick,
   // so at most one edge pulse can appear in any cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_ch  <= '0;
         sw_level <= '0;
         sw_rise  <= '0;
         sw_fall  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sw_rise <= '0;
         sw_fall <= '0;
         if (slot_tick) begin
            slot_ch      <= (slot_ch == LAST_CH) ? '0 : slot_ch + 1'b1;
            cnt[slot_ch] <= cnt_next;
            if (cur_flip) begin
               sw_level[slot_ch] <= cur_sync;
               sw_rise[slot_ch]  <= cur_sync;
               sw_fall[slot_ch]  <= ~cur_sync;
            end
         end
      end
   end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler with N_CH=4, TICK_DIV=4, STABLE_COUNT=3.
// A slot-level model is compared every cycle. Directed literal checks pin
// the expected event times.
module tb_debounce_scheduler;

   localparam int NC = 4;
   localparam int TD = 4;
   localparam int SC = 3;

   logic       clk;
   logic       reset;
   logic [3:0] sw_in;
   logic [3:0] sw_level;
   logic [3:0] sw_rise;
   logic [3:0] sw_fall;
   logic [1:0] slot_ch;
   logic       slot_tick;

   int tests = 0;
   int fails = 0;

   debounce_scheduler #(
      .N_CH         (NC),
      .TICK_DIV     (TD),
      .STABLE_COUNT (SC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sw_in     (sw_in),
      .sw_level  (sw_level),
      .sw_rise   (sw_rise),
      .sw_fall   (sw_fall),
      .slot_ch   (slot_ch),
      .slot_tick (slot_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs as seen at each active edge.
   logic [3:0] cap_in;
   logic       cap_rst;
   initial begin
      forever begin
         @(posedge clk);
         cap_in  = sw_in;
         cap_rst = reset;
      end
   end

   // Model: edge count since reset release, 2-edge input delay, per-channel run
   // of consecutive differing slot samples.
   int         m_e = 0;
   logic       m_valid = 1'b0;
   logic [3:0] d1, d2, sync_now;
   logic [3:0] m_level, m_rise, m_fall;
   int         m_run [NC];

   initial begin
      int ch;
      forever begin
         @(negedge clk);
         if (cap_rst === 1'b1) begin
            m_e = 0; d1 = '0; d2 = '0;
            m_level = '0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < NC; i++) m_run[i] = 0;
            m_valid = 1'b1;
         end else if (m_valid) begin
            sync_now = d2;
            d2 = d1;
            d1 = cap_in;
            m_rise = '0;
            m_fall = '0;
            if (m_e % TD == TD - 1) begin
               ch = (m_e / TD) % NC;
               if (sync_now[ch] != m_level[ch]) begin
                  m_run[ch]++;
                  if (m_run[ch] == SC) begin
                     m_level[ch] = sync_now[ch];
                     m_rise[ch]  = sync_now[ch];
                     m_fall[ch]  = ~sync_now[ch];
                     m_run[ch]   = 0;
                  end
               end else begin
                  m_run[ch] = 0;
               end
            end
            m_e++;
         end
         if (m_valid) begin
            chk("model_level", {28'd0, sw_level}, {28'd0, m_level});
            chk("model_rise",  {28'd0, sw_rise},  {28'd0, m_rise});
            chk("model_fall",  {28'd0, sw_fall},  {28'd0, m_fall});
            chk("model_slot",  {30'd0, slot_ch},  32'((m_e / TD) % NC));
            chk("model_tick",  {31'd0, slot_tick}, {31'd0, (m_e % TD) == TD - 1});
         end
      end
   end

   task automatic wait_e(input int target);
      int guard = 0;
      while (m_e != target) begin
         @(negedge clk);
         #1;
         guard++;
         if (guard > 2000) begin
            tests++;
            fails++;
            $display("FAIL wait_e: edge count %0d expected %0d", m_e, target);
            return;
         end
      end
   endtask

   task automatic start_run(input logic [3:0] v);
      @(negedge clk);
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_level", {28'd0, sw_level}, 32'd0);
      chk("rst_pulse", {24'd0, sw_rise, sw_fall}, 32'd0);
      chk("rst_slot",  {30'd0, slot_ch}, 32'd0);
      chk("rst_tick",  {31'd0, slot_tick}, 32'd0);
      reset = 1'b0;
      sw_in = v;
   endtask

   initial begin
      reset = 1'b1;
      sw_in = '0;

      // Stable press on ch0, glitch on ch1, then release of ch0.
      start_run(4'b0011);
      wait_e(9);  sw_in = 4'b0001;
      wait_e(35); chk("press_lvl_before", {28'd0, sw_level}, 32'h0);
      wait_e(36); chk("press_lvl", {28'd0, sw_level}, 32'h1);
                  chk("press_rise", {28'd0, sw_rise}, 32'h1);
      wait_e(37); chk("press_rise_clr", {28'd0, sw_rise}, 32'h0);
                  chk("glitch_lvl", {28'd0, sw_level}, 32'h1);
      wait_e(40); sw_in = 4'b0000;
      wait_e(83); chk("rel_lvl_before", {28'd0, sw_level}, 32'h1);
      wait_e(84); chk("rel_lvl", {28'd0, sw_level}, 32'h0);
                  chk("rel_fall", {28'd0, sw_fall}, 32'h1);
                  chk("rel_rise", {28'd0, sw_rise}, 32'h0);
      wait_e(85); chk("rel_fall_clr", {28'd0, sw_fall}, 32'h0);

      // Simultaneous press on all channels resolves staggered by one slot.
      start_run(4'b1111);
      wait_e(36); chk("sim_lvl0", {28'd0, sw_level}, 32'h1);
                  chk("sim_rise0", {28'd0, sw_rise}, 32'h1);
      wait_e(39); chk("sim_hold", {24'd0, sw_level, sw_rise}, 32'h10);
      wait_e(40); chk("sim_lvl1", {24'd0, sw_level, sw_rise}, 32'h32);
      wait_e(44); chk("sim_lvl2", {24'd0, sw_level, sw_rise}, 32'h74);
      wait_e(48); chk("sim_lvl3", {24'd0, sw_level, sw_rise}, 32'hf8);
      wait_e(49); chk("sim_rise_clr", {28'd0, sw_rise}, 32'h0);

      // Reset in the middle of a debounce (ch0 count at 2) discards progress.
      start_run(4'b0001);
      wait_e(25); reset = 1'b1;
      @(negedge clk); #1;
      chk("mid_rst_lvl",  {28'd0, sw_level}, 32'h0);
      chk("mid_rst_slot", {30'd0, slot_ch}, 32'h0);
      chk("mid_rst_tick", {31'd0, slot_tick}, 32'h0);
      @(negedge clk); #1;
      reset = 1'b0;
      wait_e(20); chk("mid_no_early", {28'd0, sw_level}, 32'h0);
      wait_e(35); chk("mid_lvl_before", {28'd0, sw_level}, 32'h0);
      wait_e(36); chk("mid_lvl", {28'd0, sw_level}, 32'h1);
                  chk("mid_rise", {28'd0, sw_rise}, 32'h1);

      // Channel pointer wrap and slot_tick period over 12 slots.
      start_run(4'b0000);
      for (int k = 0; k < 12; k++) begin
         wait_e(4 * k + 3);
         chk("ptr_tick_hi", {31'd0, slot_tick}, 32'h1);
         chk("ptr_slot",    {30'd0, slot_ch}, 32'(k % 4));
         wait_e(4 * k + 4);
         chk("ptr_tick_lo", {31'd0, slot_tick}, 32'h0);
         chk("ptr_adv",     {30'd0, slot_ch}, 32'((k + 1) % 4));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
